// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader
// Front end for the combinational decision-tree classifier. It collects a
// byte-serial feature frame, holds the assembled sample on the tree inputs,
// waits a fixed settle time, then captures the tree's class and offers it
// with a running sample index.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready feature byte handshake (in_ready registered, state only)
//   in_data, in_last  feature byte, end-of-frame marker
//   x_flat            assembled sample to the tree, X<k> at [(k+1)*W-1:k*W]
//   tree_class        combinational class from the tree
//   res_valid/ready   result handshake
//   res_class, res_idx captured class and index of the producing sample
//   frame_err         one-cycle pulse on a short or long frame
module dtree_feature_loader #(
  parameter int unsigned N_FEAT     = 5,
  parameter int unsigned W          = 8,
  parameter int unsigned CLASS_W    = 1,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic                  in_last,
  output logic [N_FEAT*W-1:0]   x_flat,
  input  logic [CLASS_W-1:0]    tree_class,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CLASS_W-1:0]    res_class,
  output logic [15:0]           res_idx,
  output logic                  frame_err
);

  localparam int unsigned KW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned XW    = N_FEAT * W;
  localparam int unsigned IDX_W = 16;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic [KW-1:0]    K_LAST   = KW'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]         state, state_nxt;
  logic [KW-1:0]      k, k_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]      x_nxt;
  logic               res_valid_nxt;
  logic [CLASS_W-1:0] res_class_nxt;
  logic [IDX_W-1:0]   res_idx_nxt;
  logic               frame_err_nxt;
  logic               in_ready_nxt;
  logic               xfer;

  assign xfer = in_valid && in_ready;

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    cnt_nxt       = cnt;
    x_nxt         = x_flat;
    res_valid_nxt = res_valid;
    res_class_nxt = res_class;
    res_idx_nxt   = res_idx;
    frame_err_nxt = 1'b0;

    case (state)
      ST_LOAD: begin
        if (xfer) begin
          for (int unsigned i = 0; i < N_FEAT; i++) begin
            if (k == KW'(i)) x_nxt[i*W +: W] = in_data;
          end
          if (k == K_LAST) begin
            k_nxt = '0;
            if (in_last) begin
              state_nxt = ST_SETTLE;
              cnt_nxt   = CNT_INIT;
            end else begin
              // Too many bytes: keep the sample, swallow the rest of the frame
              frame_err_nxt = 1'b1;
              state_nxt     = ST_DRAIN;
            end
          end else if (in_last) begin
            // Frame ended early: restart slot filling, no result
            frame_err_nxt = 1'b1;
            k_nxt         = '0;
          end else begin
            k_nxt = k + KW'(1);
          end
        end
      end

      ST_SETTLE: begin
        if (cnt == '0) begin
          res_class_nxt = tree_class;
          res_valid_nxt = 1'b1;
          state_nxt     = ST_RESULT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_RESULT: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          res_idx_nxt   = res_idx + IDX_W'(1);
          state_nxt     = ST_LOAD;
        end
      end

      ST_DRAIN: begin
        if (xfer && in_last) begin
          state_nxt = ST_LOAD;
          k_nxt     = '0;
        end
      end

      default: begin
        state_nxt = ST_LOAD;
        k_nxt     = '0;
      end
    endcase

    in_ready_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      k         <= '0;
      cnt       <= '0;
      x_flat    <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_idx   <= '0;
      frame_err <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      x_flat    <= x_nxt;
      res_valid <= res_valid_nxt;
      res_class <= res_class_nxt;
      res_idx   <= res_idx_nxt;
      frame_err <= frame_err_nxt;
      in_ready  <= in_ready_nxt;
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Self-checking bench for dtree_feature_loader: directed and randomized
// frames compared against a frame-level reference model.
module tb_dtree_feature_loader;

  localparam int unsigned N_FEAT     = 5;
  localparam int unsigned W          = 8;
  localparam int unsigned CLASS_W    = 1;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned XW         = N_FEAT * W;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_data;
  logic               in_last;
  logic [XW-1:0]      x_flat;
  logic [CLASS_W-1:0] tree_class;
  logic               res_valid;
  logic               res_ready;
  logic [CLASS_W-1:0] res_class;
  logic [15:0]        res_idx;
  logic               frame_err;

  dtree_feature_loader #(
    .N_FEAT(N_FEAT), .W(W), .CLASS_W(CLASS_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .x_flat(x_flat), .tree_class(tree_class),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_idx(res_idx), .frame_err(frame_err)
  );

  // Stand-in tree: class is 1 when X0 exceeds 15
  assign tree_class = CLASS_W'(x_flat[W-1:0] > 8'd15);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  always @(negedge clk) if (rst_n && frame_err) err_pulses++;

  // Reference model state
  logic [W-1:0]  fb [16];
  int            flen;
  logic [XW-1:0] model_x;
  int            exp_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_frame(input int len);
    flen = len;
    for (int i = 0; i < len; i++) fb[i] = W'($urandom_range(0, 255));
  endtask

  // Drive one frame byte by byte; the model fills slot i for bytes 0..N_FEAT-1
  task automatic send_frame();
    int  waited;
    logic exp_err;
    for (int i = 0; i < flen; i++) begin
      in_valid = 1'b1;
      in_data  = fb[i];
      in_last  = (i == flen - 1);
      waited   = 0;
      while (!in_ready && waited < 50) begin
        tick();
        waited++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
      tick();
      if (i < int'(N_FEAT)) model_x[i*W +: W] = fb[i];
      exp_err = ((i == int'(N_FEAT) - 1) && (flen > int'(N_FEAT))) ||
                ((i < int'(N_FEAT) - 1) && (i == flen - 1));
      check("frame_err_pulse", 64'(frame_err), 64'(exp_err));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result();
    int cycles;
    cycles = 0;
    while (!res_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    check("latency", 64'(cycles), 64'(SETTLE_CYC));
    check("res_valid_up", 64'(res_valid), 64'd1);
    check("x_flat", 64'(x_flat), 64'(model_x));
    check("res_class", 64'(res_class), (model_x[W-1:0] > 8'd15) ? 64'd1 : 64'd0);
    check("res_idx", 64'(res_idx), 64'(exp_idx));
    check("in_ready_blocked", 64'(in_ready), 64'd0);
  endtask

  task automatic handshake();
    int h;
    h = $urandom_range(0, 3);
    for (int i = 0; i < h; i++) begin
      tick();
      check("res_hold_valid", 64'(res_valid), 64'd1);
      check("res_hold_idx", 64'(res_idx), 64'(exp_idx));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_idx = (exp_idx + 1) % 65536;
    check("res_valid_down", 64'(res_valid), 64'd0);
    check("res_idx_inc", 64'(res_idx), 64'(exp_idx));
    check("in_ready_reopen", 64'(in_ready), 64'd1);
  endtask

  task automatic good_frame();
    int e0;
    e0 = err_pulses;
    send_frame();
    wait_result();
    handshake();
    check("no_err_good", 64'(err_pulses - e0), 64'd0);
  endtask

  task automatic bad_frame();
    int e0;
    e0 = err_pulses;
    send_frame();
    for (int i = 0; i < 6; i++) tick();
    check("err_count", 64'(err_pulses - e0), 64'd1);
    check("no_result", 64'(res_valid), 64'd0);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    check("x_flat_kept", 64'(x_flat), 64'(model_x));
  endtask

  initial begin
    logic [XW-1:0] x_hold;
    logic [CLASS_W-1:0] c_hold;
    int len;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
    model_x = '0; exp_idx = 0; flen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_x_flat", 64'(x_flat), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_class", 64'(res_class), 64'd0);
    check("rst_res_idx", 64'(res_idx), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);

    // Nominal sample 10,20,30,40,50
    flen = 5; fb[0] = 8'd10; fb[1] = 8'd20; fb[2] = 8'd30; fb[3] = 8'd40; fb[4] = 8'd50;
    send_frame();
    check("nominal_x_const", 64'(x_flat), 64'h32281E140A);
    wait_result();
    check("nominal_class0", 64'(res_class), 64'd0);
    handshake();

    // Second sample with X0=100
    make_frame(5); fb[0] = 8'd100;
    good_frame();

    // Backpressure with the next frame already pending
    make_frame(5);
    send_frame();
    wait_result();
    x_hold = x_flat;
    c_hold = res_class;
    make_frame(5);
    in_valid = 1'b1; in_data = fb[0]; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_class", 64'(res_class), 64'(c_hold));
      check("bp_x_flat", 64'(x_flat), 64'(x_hold));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_idx = (exp_idx + 1) % 65536;
    check("bp_release_idx", 64'(res_idx), 64'(exp_idx));
    good_frame();

    // Short frame then a good one
    make_frame(3);
    bad_frame();
    make_frame(5);
    good_frame();

    // Long frame then a good one
    make_frame(7);
    bad_frame();
    make_frame(5);
    good_frame();

    // Randomized mix; res_ready waves while no result is pending
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 4);
        1: len = $urandom_range(6, 9);
        default: len = 5;
      endcase
      make_frame(len);
      res_ready = 1'($urandom_range(0, 1));
      if (len == 5) begin
        send_frame();
        res_ready = 1'b0;
        wait_result();
        handshake();
      end else begin
        bad_frame();
        res_ready = 1'b0;
      end
    end

    // Asynchronous reset while settling
    make_frame(5);
    send_frame();
    #2 rst_n = 1'b0;
    #1;
    check("arst_x_flat", 64'(x_flat), 64'd0);
    check("arst_res_valid", 64'(res_valid), 64'd0);
    check("arst_res_idx", 64'(res_idx), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    model_x = '0;
    exp_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst_no_stale", 64'(res_valid), 64'd0);
    end
    make_frame(5);
    good_frame();

    // Index wrap from 0xFFFF
    make_frame(5);
    send_frame();
    wait_result();
    force dut.res_idx = 16'hFFFF;
    tick();
    release dut.res_idx;
    #1;
    exp_idx = 16'hFFFF;
    check("wrap_preload", 64'(res_idx), 64'(exp_idx));
    handshake();
    check("wrap_zero", 64'(res_idx), 64'd0);
    make_frame(5);
    good_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
